// File: rtl/acp_pkg.sv
// Shared definitions for the note scheduler: opcodes, FSM states, field widths
// and the packed command layout (header struct followed by a payload field).
package acp_pkg;

    localparam logic OP_NOTE = 1'b0;
    localparam logic OP_WAIT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int CH_W   = 2;
    localparam int ATT_W  = 2;
    localparam int DEC_W  = 2;
    localparam int LEN_W  = 3;
    localparam int WAIT_W = 8;

    typedef struct packed {
        logic             op;
        logic [CH_W-1:0]  ch;
        logic [ATT_W-1:0] attack;
        logic [DEC_W-1:0] decay;
        logic [LEN_W-1:0] length;
    } cmd_hdr_t;

    localparam int HDR_W = $bits(cmd_hdr_t);

    // The payload carries the period for NOTE and the tick count for WAIT.
    function automatic int payload_w(input int per_w);
        return (per_w > WAIT_W) ? per_w : WAIT_W;
    endfunction

    function automatic int cmd_w(input int per_w);
        return HDR_W + payload_w(per_w);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// DEPTH-entry synchronous command FIFO with push, pop and a synchronous flush
// that has priority over both.
module cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         note_clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign rd_data   = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge note_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// Command-driven note sequencer: buffers NOTE/WAIT commands and distributes
// per-channel envelope settings with a one-cycle trigger. Option: NOTE_BUSY_HOLD_EN.
module note_scheduler
    import acp_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DEPTH  = 4,
    parameter int PER_W  = 11
) (
    input  logic                    note_clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_op,
    input  logic [1:0]              cmd_ch,
    input  logic [1:0]              cmd_attack,
    input  logic [1:0]              cmd_decay,
    input  logic [2:0]              cmd_length,
    input  logic [PER_W-1:0]        cmd_period,
    input  logic [7:0]              cmd_wait,
    input  logic                    flush,
    input  logic [NUM_CH-1:0]       ch_enable,
    output logic [NUM_CH-1:0]       ch_trig,
    output logic [2*NUM_CH-1:0]     ch_attack,
    output logic [2*NUM_CH-1:0]     ch_decay,
    output logic [3*NUM_CH-1:0]     ch_length,
    output logic [PER_W*NUM_CH-1:0] ch_period,
    output logic                    busy,
    output logic                    err_bad_ch,
    input  logic                    err_clr
);

    localparam int PAY_W = payload_w(PER_W);
    localparam int CMD_W = cmd_w(PER_W);

    state_t                    state_r;
    logic [WAIT_W-1:0]         wait_cnt_r;
    logic [NUM_CH-1:0]         trig_r;
    logic [2*NUM_CH-1:0]       attack_r;
    logic [2*NUM_CH-1:0]       decay_r;
    logic [3*NUM_CH-1:0]       length_r;
    logic [PER_W*NUM_CH-1:0]   period_r;
    logic                      err_r;

    cmd_hdr_t                  in_hdr_s;
    logic [PAY_W-1:0]          in_pay_s;
    cmd_hdr_t                  head_hdr_s;
    logic [PAY_W-1:0]          head_pay_s;
    logic [CMD_W-1:0]          head_data_s;
    logic [WAIT_W-1:0]         head_wait_s;
    logic [PER_W-1:0]          head_per_s;
    logic                      full_s;
    logic                      empty_s;
    logic                      push_s;
    logic                      pop_s;
    logic                      ch_ok_s;
    logic                      hold_s;
    logic                      bad_pop_s;

    // Pack the host command; the payload holds the tick count for WAIT, the period for NOTE.
    always_comb begin
        in_hdr_s.op     = cmd_op;
        in_hdr_s.ch     = cmd_ch;
        in_hdr_s.attack = cmd_attack;
        in_hdr_s.decay  = cmd_decay;
        in_hdr_s.length = cmd_length;
        if (cmd_op == OP_WAIT) begin
            in_pay_s = PAY_W'(cmd_wait);
        end else begin
            in_pay_s = PAY_W'(cmd_period);
        end
    end

    assign cmd_ready = !full_s && !flush;
    assign push_s    = cmd_valid && cmd_ready;

    cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .note_clk (note_clk),
        .rst      (rst),
        .push     (push_s),
        .pop      (pop_s),
        .flush    (flush),
        .wr_data  ({in_hdr_s, in_pay_s}),
        .rd_data  (head_data_s),
        .full     (full_s),
        .empty    (empty_s)
    );

    assign {head_hdr_s, head_pay_s} = head_data_s;
    assign head_wait_s = head_pay_s[WAIT_W-1:0];
    assign head_per_s  = head_pay_s[PER_W-1:0];
    assign ch_ok_s     = ({1'b0, head_hdr_s.ch} < 3'(NUM_CH));

`ifdef NOTE_BUSY_HOLD_EN
    // A NOTE aimed at a still-active channel stalls at the head of the queue.
    always_comb begin
        hold_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((head_hdr_s.op == OP_NOTE) && (head_hdr_s.ch == 2'(i)) && ch_enable[i]) begin
                hold_s = 1'b1;
            end else begin
                hold_s = hold_s;
            end
        end
    end
`else
    logic unused_enable_s;
    assign unused_enable_s = ^ch_enable;
    assign hold_s          = 1'b0;
`endif

    assign pop_s     = (state_r == ST_IDLE) && !empty_s && !flush && !hold_s;
    assign bad_pop_s = pop_s && (head_hdr_s.op == OP_NOTE) && !ch_ok_s;

    // Sequencer FSM with registered channel settings, trigger pulses and error flag.
    always_ff @(posedge note_clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= {WAIT_W{1'b0}};
            trig_r     <= {NUM_CH{1'b0}};
            attack_r   <= {(2*NUM_CH){1'b0}};
            decay_r    <= {(2*NUM_CH){1'b0}};
            length_r   <= {(3*NUM_CH){1'b0}};
            period_r   <= {(PER_W*NUM_CH){1'b0}};
            err_r      <= 1'b0;
        end else begin
            trig_r <= {NUM_CH{1'b0}};
            if (bad_pop_s) begin
                err_r <= 1'b1;
            end else if (err_clr) begin
                err_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        if (head_hdr_s.op == OP_NOTE) begin
                            if (ch_ok_s) begin
                                for (int i = 0; i < NUM_CH; i++) begin
                                    if (head_hdr_s.ch == 2'(i)) begin
                                        attack_r[2*i +: 2]         <= head_hdr_s.attack;
                                        decay_r[2*i +: 2]          <= head_hdr_s.decay;
                                        length_r[3*i +: 3]         <= head_hdr_s.length;
                                        period_r[PER_W*i +: PER_W] <= head_per_s;
                                        trig_r[i]                  <= 1'b1;
                                    end
                                end
                                state_r <= ST_ISSUE;
                            end
                        end else if (head_wait_s != {WAIT_W{1'b0}}) begin
                            wait_cnt_r <= head_wait_s;
                            state_r    <= ST_WAIT;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_IDLE;
                end
                // Leaving on count==1 gives exactly W cycles in WAIT.
                ST_WAIT: begin
                    if (flush || (wait_cnt_r == 8'd1)) begin
                        wait_cnt_r <= {WAIT_W{1'b0}};
                        state_r    <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 8'd1;
                    end
                end
                default: begin
                    wait_cnt_r <= {WAIT_W{1'b0}};
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign ch_trig    = trig_r;
    assign ch_attack  = attack_r;
    assign ch_decay   = decay_r;
    assign ch_length  = length_r;
    assign ch_period  = period_r;
    assign err_bad_ch = err_r;
    assign busy       = !empty_s || (state_r != ST_IDLE);

endmodule

// File: tb/tb_note_scheduler.sv
// Directed self-checking bench for note_scheduler (NUM_CH=3, DEPTH=4, PER_W=11).
module tb_note_scheduler;

    logic        note_clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [1:0]  cmd_ch;
    logic [1:0]  cmd_attack;
    logic [1:0]  cmd_decay;
    logic [2:0]  cmd_length;
    logic [10:0] cmd_period;
    logic [7:0]  cmd_wait;
    logic        flush;
    logic [2:0]  ch_enable;
    logic [2:0]  ch_trig;
    logic [5:0]  ch_attack;
    logic [5:0]  ch_decay;
    logic [8:0]  ch_length;
    logic [32:0] ch_period;
    logic        busy;
    logic        err_bad_ch;
    logic        err_clr;

    int vectors = 0;
    int miscompares = 0;

    note_scheduler #(.NUM_CH(3), .DEPTH(4), .PER_W(11)) dut (
        .note_clk   (note_clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_ch     (cmd_ch),
        .cmd_attack (cmd_attack),
        .cmd_decay  (cmd_decay),
        .cmd_length (cmd_length),
        .cmd_period (cmd_period),
        .cmd_wait   (cmd_wait),
        .flush      (flush),
        .ch_enable  (ch_enable),
        .ch_trig    (ch_trig),
        .ch_attack  (ch_attack),
        .ch_decay   (ch_decay),
        .ch_length  (ch_length),
        .ch_period  (ch_period),
        .busy       (busy),
        .err_bad_ch (err_bad_ch),
        .err_clr    (err_clr)
    );

    initial note_clk = 1'b0;
    always #5 note_clk = ~note_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge note_clk);
        #1;
    endtask

    task automatic push_note(input logic [1:0] ch, input logic [1:0] att, input logic [1:0] dec,
                             input logic [2:0] len, input logic [10:0] per);
        cmd_valid  = 1'b1;
        cmd_op     = 1'b0;
        cmd_ch     = ch;
        cmd_attack = att;
        cmd_decay  = dec;
        cmd_length = len;
        cmd_period = per;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic push_wait(input logic [7:0] w);
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        cmd_wait  = w;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_ch = 2'd0; cmd_attack = 2'd0;
        cmd_decay = 2'd0; cmd_length = 3'd0; cmd_period = 11'd0; cmd_wait = 8'd0;
        flush = 1'b0; ch_enable = 3'b000; err_clr = 1'b0;
        #12;
        check("rst_ready", 64'(cmd_ready), 64'd1);
        check("rst_trig", 64'(ch_trig), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_period", 64'(ch_period), 64'd0);
        rst = 1'b0;

        // NOTE ch1: trigger one edge after acceptance, only ch1 fields move
        push_note(2'd1, 2'd2, 2'd1, 3'd5, 11'h1A0);
        check("t1_trig_k", 64'(ch_trig), 64'd0);
        check("t1_busy_k", 64'(busy), 64'd1);
        tick();
        check("t1_trig", 64'(ch_trig), 64'h2);
        check("t1_attack", 64'(ch_attack), 64'h08);
        check("t1_decay", 64'(ch_decay), 64'h04);
        check("t1_length", 64'(ch_length), 64'h028);
        check("t1_period", 64'(ch_period), 64'hD0000);
        tick();
        check("t1_trig_drop", 64'(ch_trig), 64'd0);
        check("t1_busy_idle", 64'(busy), 64'd0);
        check("t1_attack_hold", 64'(ch_attack), 64'h08);

        // NOTE ch0, WAIT 4, NOTE ch2: ISSUE 1 + idle pop 1 + WAIT 4 + idle pop 1 = 7 edges apart
        push_note(2'd0, 2'd1, 2'd3, 3'd2, 11'h055);
        push_wait(8'd4);
        check("t2_trig_ch0", 64'(ch_trig), 64'h1);
        push_note(2'd2, 2'd3, 2'd2, 3'd6, 11'h7FF);
        check("t2_gap_e2", 64'(ch_trig), 64'd0);
        for (int i = 3; i <= 7; i++) begin
            tick();
            check($sformatf("t2_gap_e%0d", i), 64'(ch_trig), 64'd0);
        end
        tick();
        check("t2_trig_ch2", 64'(ch_trig), 64'h4);
        check("t2_attack", 64'(ch_attack), 64'h39);
        check("t2_decay", 64'(ch_decay), 64'h27);
        check("t2_length", 64'(ch_length), 64'h1AA);
        check("t2_per0", 64'(ch_period[10:0]), 64'h055);
        check("t2_per1", 64'(ch_period[21:11]), 64'h1A0);
        check("t2_per2", 64'(ch_period[32:22]), 64'h7FF);
        tick();
        check("t2_drop", 64'(ch_trig), 64'd0);

        // Stall with WAIT 200, fill the FIFO, then flush
        push_wait(8'd200);
        for (int i = 0; i < 4; i++) begin
            push_note(2'd0, 2'd3, 2'd3, 3'd7, 11'h3FF);
            check($sformatf("t3_ready_%0d", i), 64'(cmd_ready), (i == 3) ? 64'd0 : 64'd1);
        end
        cmd_valid = 1'b1;
        tick();
        check("t3_full_busy", 64'(busy), 64'd1);
        check("t3_full_ready", 64'(cmd_ready), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("t3_flush_ready", 64'(cmd_ready), 64'd1);
        check("t3_flush_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t3_no_trig_%0d", i), 64'(ch_trig), 64'd0);
        end
        check("t3_attack_kept", 64'(ch_attack), 64'h39);

        // Flush beats a push offered in the same cycle
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_wait = 8'd9; flush = 1'b1;
        #1;
        check("t3b_ready_flush", 64'(cmd_ready), 64'd0);
        tick();
        cmd_valid = 1'b0; flush = 1'b0;
        #1;
        check("t3b_not_accepted", 64'(busy), 64'd0);

        // Bad channel: no trigger, sticky error, next NOTE normal
        push_note(2'd3, 2'd0, 2'd0, 3'd0, 11'h000);
        check("t4_err_pre", 64'(err_bad_ch), 64'd0);
        tick();
        check("t4_err_set", 64'(err_bad_ch), 64'd1);
        check("t4_no_trig", 64'(ch_trig), 64'd0);
        check("t4_attack_kept", 64'(ch_attack), 64'h39);
        tick();
        push_note(2'd0, 2'd2, 2'd0, 3'd4, 11'h100);
        tick();
        check("t4_ch0_trig", 64'(ch_trig), 64'h1);
        check("t4_ch0_attack", 64'(ch_attack[1:0]), 64'd2);
        check("t4_err_sticky", 64'(err_bad_ch), 64'd1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_err_clr", 64'(err_bad_ch), 64'd0);
        push_note(2'd3, 2'd1, 2'd1, 3'd1, 11'h001);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_set_wins", 64'(err_bad_ch), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_err_clr2", 64'(err_bad_ch), 64'd0);

        // Back-to-back NOTEs to ch0: pulse, low, pulse
        push_note(2'd0, 2'd1, 2'd1, 3'd1, 11'h011);
        push_note(2'd0, 2'd3, 2'd3, 3'd2, 11'h022);
        check("t5_pulse1", 64'(ch_trig), 64'h1);
        check("t5_len1", 64'(ch_length[2:0]), 64'd1);
        tick();
        check("t5_gap", 64'(ch_trig), 64'd0);
        tick();
        check("t5_pulse2", 64'(ch_trig), 64'h1);
        check("t5_len2", 64'(ch_length[2:0]), 64'd2);
        check("t5_per2", 64'(ch_period[10:0]), 64'h022);
        tick();
        check("t5_drop", 64'(ch_trig), 64'd0);

        // NOTE to a channel whose envelope is still active
        ch_enable = 3'b010;
        push_note(2'd1, 2'd0, 2'd0, 3'd3, 11'h0AA);
`ifdef NOTE_BUSY_HOLD_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t6_held_trig_%0d", i), 64'(ch_trig), 64'd0);
            check($sformatf("t6_held_busy_%0d", i), 64'(busy), 64'd1);
        end
        ch_enable = 3'b000;
        tick();
        check("t6_release_trig", 64'(ch_trig), 64'h2);
        check("t6_release_per", 64'(ch_period[21:11]), 64'h0AA);
`else
        tick();
        check("t6_steal_trig", 64'(ch_trig), 64'h2);
        check("t6_steal_per", 64'(ch_period[21:11]), 64'h0AA);
`endif
        ch_enable = 3'b000;
        tick();
        check("t6_drop", 64'(ch_trig), 64'd0);

        // Asynchronous reset in the middle of a WAIT
        push_wait(8'd50);
        tick(); tick(); tick();
        check("t7_busy_wait", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("t7_rst_busy", 64'(busy), 64'd0);
        check("t7_rst_ready", 64'(cmd_ready), 64'd1);
        check("t7_rst_attack", 64'(ch_attack), 64'd0);
        check("t7_rst_decay", 64'(ch_decay), 64'd0);
        check("t7_rst_length", 64'(ch_length), 64'd0);
        check("t7_rst_period", 64'(ch_period), 64'd0);
        check("t7_rst_trig", 64'(ch_trig), 64'd0);
        check("t7_rst_err", 64'(err_bad_ch), 64'd0);
        #3;
        rst = 1'b0;
        tick();
        check("t7_post_busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
